lc3_trace_capture: RTL and testbench

Synthesizable per-instruction trace recorder that sits directly downstream of the `lc3` core's debug ports. It turns the bus- and state-level activity into one record per retired instruction: PC, IR, register-write flag and data, memory-write flag, address and data. Records are buffered in a FIFO and streamed out as 16-bit words in PennSim trace field order, for comparison against the golden simulator.

---
 rtl/lc3_trace_capture.sv | 184 ++++++++++++++++++
 tb/tb_lc3_trace_capture.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_trace_capture.sv
// lc3_trace_capture
//
// Per-instruction trace recorder for the lc3 core. It watches the core's debug
// ports and turns each retired instruction into one record:
// PC, IR, register write (flag, data) and memory write (flag, address, data).
// Records are queued in a FIFO and streamed out as seven 16-bit words in
// PennSim trace field order:
// PC, IR, reg-write flag, reg data, mem-write flag, mem addr, mem data.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   capture_en             enables record generation at fetch entry
//   debug*                 core state / PC / IR / bus / strobes / MAR / MDR
//   trace_valid/ready      word handshake; trace_data is the current word
//   trace_last             high on the seventh (last) word of a record
//   record_count           records pushed (wraps)
//   overflow_count         records dropped on a full FIFO (saturates)
//   halted                 sticky, the halt IR has been seen
module lc3_trace_capture #(
  parameter int          DEPTH       = 16,
  parameter logic [5:0]  FETCH_STATE = 6'd18,
  parameter logic [15:0] HALT_IR     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture_en,
  input  logic [5:0]  debugCurrentState,
  input  logic [15:0] debugPC,
  input  logic [15:0] debugInstruction,
  input  logic [15:0] debugDatabus,
  input  logic        debugLDREG,
  input  logic        debugRW,
  input  logic [15:0] debugMARRead,
  input  logic [15:0] debugMDRRead,
  output logic        trace_valid,
  output logic [15:0] trace_data,
  output logic        trace_last,
  input  logic        trace_ready,
  output logic [15:0] record_count,
  output logic [15:0] overflow_count,
  output logic        halted
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Record layout: pc, ir, rw_f, rw_d, mw_f, mw_a, mw_d (82 bits of payload).
  localparam int         REC_W     = 82;
  localparam logic [2:0] LAST_WORD = 3'd6;

  logic [5:0]  state_q;
  logic [15:0] pc_acc;
  logic [15:0] rw_d;
  logic [15:0] mw_a;
  logic [15:0] mw_d;
  logic        rw_f;
  logic        mw_f;
  logic        have_pc;

  logic        fetch_entry;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic        empty;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [2:0]  word_idx;

  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] head;

  // Fetch entry is the rising edge into the FETCH state.
  assign fetch_entry = (debugCurrentState == FETCH_STATE) && (state_q != FETCH_STATE)
                       && capture_en && !halted;

  // The IR still holds the instruction that just completed, so the record is
  // formed from it plus the accumulators collected since the previous fetch.
  assign push_req = fetch_entry && have_pc && (debugInstruction != 16'h0000)
                    && (debugInstruction != HALT_IR);

  assign rec_in = {pc_acc, debugInstruction, rw_f, rw_d, mw_f, mw_a, mw_d};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = trace_valid && trace_ready && (word_idx == LAST_WORD);
  // A push into a full FIFO still lands if the head is leaving on this edge.
  assign push_ok = push_req && (!full || pop);

  // Core activity tracking and accumulators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= 6'h00;
      pc_acc  <= 16'h0000;
      rw_f    <= 1'b0;
      rw_d    <= 16'h0000;
      mw_f    <= 1'b0;
      mw_a    <= 16'h0000;
      mw_d    <= 16'h0000;
      have_pc <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= debugCurrentState;
      if (fetch_entry) begin
        pc_acc  <= debugPC;
        have_pc <= 1'b1;
        // Strobes seen in this cycle already belong to the new instruction.
        rw_f    <= debugLDREG;
        rw_d    <= debugLDREG ? debugDatabus : 16'h0000;
        mw_f    <= debugRW;
        mw_a    <= debugRW ? debugMARRead : 16'h0000;
        mw_d    <= debugRW ? debugMDRRead : 16'h0000;
        if (debugInstruction == HALT_IR) begin
          halted <= 1'b1;
        end
      end else begin
        if (debugLDREG) begin
          rw_f <= 1'b1;
          rw_d <= debugDatabus;
        end
        if (debugRW) begin
          mw_f <= 1'b1;
          mw_a <= debugMARRead;
          mw_d <= debugMDRRead;
        end
      end
    end
  end

  // Record storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= rec_in;
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // Pointers, word index and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      word_idx       <= 3'd0;
      record_count   <= 16'h0000;
      overflow_count <= 16'h0000;
    end else begin
      if (push_ok) begin
        wr_ptr       <= wr_ptr + {{AW{1'b0}}, 1'b1};
        record_count <= record_count + 16'd1;
      end else if (push_req && (overflow_count != 16'hFFFF)) begin
        overflow_count <= overflow_count + 16'd1;
      end
      if (trace_valid && trace_ready) begin
        if (word_idx == LAST_WORD) begin
          word_idx <= 3'd0;
          rd_ptr   <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end else begin
          word_idx <= word_idx + 3'd1;
        end
      end
    end
  end

  assign trace_valid = !empty;
  assign trace_last  = !empty && (word_idx == LAST_WORD);

  // Word select from the FIFO head; forced to zero when there is nothing to send.
  always_comb begin
    trace_data = 16'h0000;
    if (!empty) begin
      case (word_idx)
        3'd0:    trace_data = head[81:66];
        3'd1:    trace_data = head[65:50];
        3'd2:    trace_data = {15'b0, head[49]};
        3'd3:    trace_data = head[48:33];
        3'd4:    trace_data = {15'b0, head[32]};
        3'd5:    trace_data = head[31:16];
        3'd6:    trace_data = head[15:0];
        default: trace_data = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_trace_capture.sv
// Testbench for lc3_trace_capture: table-driven instruction records plus
// hand-written sequences for halt, overflow, backpressure and reset.
module tb_lc3_trace_capture;

  localparam logic [5:0] FETCH = 6'd18;
  localparam logic [5:0] IDLE  = 6'd32;

  logic        clk;
  logic        reset_n;
  logic        capture_en;
  logic [5:0]  debugCurrentState;
  logic [15:0] debugPC;
  logic [15:0] debugInstruction;
  logic [15:0] debugDatabus;
  logic        debugLDREG;
  logic        debugRW;
  logic [15:0] debugMARRead;
  logic [15:0] debugMDRRead;
  logic        trace_valid;
  logic [15:0] trace_data;
  logic        trace_last;
  logic        trace_ready;
  logic [15:0] record_count;
  logic [15:0] overflow_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  lc3_trace_capture #(.DEPTH(4), .FETCH_STATE(6'd18), .HALT_IR(16'hFFFF)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .capture_en(capture_en),
    .debugCurrentState(debugCurrentState),
    .debugPC(debugPC),
    .debugInstruction(debugInstruction),
    .debugDatabus(debugDatabus),
    .debugLDREG(debugLDREG),
    .debugRW(debugRW),
    .debugMARRead(debugMARRead),
    .debugMDRRead(debugMDRRead),
    .trace_valid(trace_valid),
    .trace_data(trace_data),
    .trace_last(trace_last),
    .trace_ready(trace_ready),
    .record_count(record_count),
    .overflow_count(overflow_count),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      pc;
    logic [15:0]      ir;
    int               ld_n;
    logic [15:0]      ld0;
    logic [15:0]      ld1;
    bit               st;
    logic [15:0]      mar;
    logic [15:0]      mdr;
    logic [6:0][15:0] exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [6:0][15:0] mk(input logic [15:0] w0, input logic [15:0] w1,
                                           input logic [15:0] w2, input logic [15:0] w3,
                                           input logic [15:0] w4, input logic [15:0] w5,
                                           input logic [15:0] w6);
    return {w6, w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One fetch-entry cycle followed by one non-fetch cycle.
  task automatic fe(input logic [15:0] pc, input logic [15:0] ir);
    debugCurrentState = FETCH;
    debugPC = pc;
    debugInstruction = ir;
    @(negedge clk);
    debugCurrentState = IDLE;
    @(negedge clk);
  endtask

  task automatic ld(input logic [15:0] d);
    debugLDREG = 1'b1;
    debugDatabus = d;
    @(negedge clk);
    debugLDREG = 1'b0;
  endtask

  task automatic st(input logic [15:0] a, input logic [15:0] d);
    debugRW = 1'b1;
    debugMARRead = a;
    debugMDRRead = d;
    @(negedge clk);
    debugRW = 1'b0;
  endtask

  // Receive n words of a record and compare each one. With rnd set, ready is
  // random and every held cycle re-checks the same expected word. With
  // fe_last set, a fetch entry is driven in the cycle of the final word.
  task automatic expect_record(input logic [6:0][15:0] w, input int n, input bit rnd,
                               input string nm, input bit fe_last,
                               input logic [15:0] fpc, input logic [15:0] fir);
    for (int k = 0; k < n; k++) begin
      int  t;
      bit  done;
      t = 0;
      done = 1'b0;
      while (!done) begin
        trace_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!trace_valid) begin
          if (t > 60) begin
            chk({nm, "_valid_timeout"}, {15'b0, trace_valid}, 16'h0001);
            trace_ready = 1'b0;
            return;
          end
        end else begin
          chk($sformatf("%s_w%0d", nm, k), trace_data, w[k]);
          chk($sformatf("%s_last%0d", nm, k), {15'b0, trace_last}, {15'b0, (k == 6)});
          if (trace_ready) begin
            done = 1'b1;
            if (fe_last && k == 6) begin
              debugCurrentState = FETCH;
              debugPC = fpc;
              debugInstruction = fir;
            end
          end
        end
        t++;
        @(negedge clk);
        debugCurrentState = IDLE;
      end
    end
    trace_ready = 1'b0;
    $display("record %s pc=%h ir=%h words=%0d", nm, w[0], w[1], n);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, {15'b0, trace_valid}, 16'h0000);
    chk({nm, "_data"}, trace_data, 16'h0000);
    chk({nm, "_last"}, {15'b0, trace_last}, 16'h0000);
    chk({nm, "_halted"}, {15'b0, halted}, 16'h0000);
    chk({nm, "_rcnt"}, record_count, 16'h0000);
    chk({nm, "_ocnt"}, overflow_count, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{pc:16'h3000, ir:16'h1261, ld_n:1, ld0:16'h0005, ld1:16'h0000, st:1'b0,
               mar:16'h0000, mdr:16'h0000,
               exp:mk(16'h3000, 16'h1261, 16'h0001, 16'h0005, 16'h0000, 16'h0000, 16'h0000)};
    tbl[1] = '{pc:16'h3001, ir:16'h3E02, ld_n:0, ld0:16'h0000, ld1:16'h0000, st:1'b1,
               mar:16'h4000, mdr:16'hBEEF,
               exp:mk(16'h3001, 16'h3E02, 16'h0000, 16'h0000, 16'h0001, 16'h4000, 16'hBEEF)};
    tbl[2] = '{pc:16'h3002, ir:16'h6283, ld_n:1, ld0:16'hABCD, ld1:16'h0000, st:1'b1,
               mar:16'h5000, mdr:16'h0042,
               exp:mk(16'h3002, 16'h6283, 16'h0001, 16'hABCD, 16'h0001, 16'h5000, 16'h0042)};
    tbl[3] = '{pc:16'h3003, ir:16'h1021, ld_n:2, ld0:16'h0001, ld1:16'h0007, st:1'b0,
               mar:16'h0000, mdr:16'h0000,
               exp:mk(16'h3003, 16'h1021, 16'h0001, 16'h0007, 16'h0000, 16'h0000, 16'h0000)};
    tbl[4] = '{pc:16'h3004, ir:16'h0E05, ld_n:0, ld0:16'h0000, ld1:16'h0000, st:1'b0,
               mar:16'h0000, mdr:16'h0000,
               exp:mk(16'h3004, 16'h0E05, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000)};

    reset_n = 1'b0;
    capture_en = 1'b1;
    debugCurrentState = IDLE;
    debugPC = 16'h0000;
    debugInstruction = 16'h0000;
    debugDatabus = 16'h0000;
    debugLDREG = 1'b0;
    debugRW = 1'b0;
    debugMARRead = 16'h0000;
    debugMDRRead = 16'h0000;
    trace_ready = 1'b0;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ---------------- table-driven records ----------------
    fe(16'h3000, 16'h0000);
    chk("prime_no_push", {15'b0, trace_valid}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].ld_n >= 1) ld(tbl[i].ld0);
      if (tbl[i].ld_n >= 2) ld(tbl[i].ld1);
      if (tbl[i].st) st(tbl[i].mar, tbl[i].mdr);
      fe(tbl[i].pc + 16'd1, tbl[i].ir);
      expect_record(tbl[i].exp, 7, 1'b0, $sformatf("tbl%0d", i), 1'b0, 16'h0, 16'h0);
      chk($sformatf("tbl%0d_rcnt", i), record_count, 16'(i + 1));
    end

    // ---------------- zero IR and halt ----------------
    ld(16'h9999);
    fe(16'h3006, 16'h0000);
    chk("zero_ir_no_push", {15'b0, trace_valid}, 16'h0000);
    chk("zero_ir_rcnt", record_count, 16'd5);
    fe(16'h3007, 16'h5020);
    expect_record(mk(16'h3006, 16'h5020, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
                  7, 1'b0, "after_zero", 1'b0, 16'h0, 16'h0);
    fe(16'h3008, 16'hFFFF);
    chk("halt_set", {15'b0, halted}, 16'h0001);
    chk("halt_no_push", {15'b0, trace_valid}, 16'h0000);
    chk("halt_rcnt", record_count, 16'd6);
    ld(16'h1111);
    fe(16'h3009, 16'h1261);
    fe(16'h300A, 16'h1262);
    chk("post_halt_no_push", {15'b0, trace_valid}, 16'h0000);
    chk("post_halt_rcnt", record_count, 16'd6);
    chk("halt_sticky", {15'b0, halted}, 16'h0001);

    // ---------------- overflow (DEPTH=4) ----------------
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst2");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    fe(16'h4000, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      ld(16'h0100 + 16'(k));
      fe(16'h4001 + 16'(k), 16'h1000 + 16'(k));
    end
    chk("ovf_rcnt", record_count, 16'd4);
    chk("ovf_ocnt", overflow_count, 16'd2);
    chk("ovf_valid", {15'b0, trace_valid}, 16'h0001);
    // Push on the final-word pop of a full FIFO must succeed.
    expect_record(mk(16'h4000, 16'h1000, 16'h0001, 16'h0100, 16'h0000, 16'h0000, 16'h0000),
                  7, 1'b0, "ovf0", 1'b1, 16'h4007, 16'h2000);
    chk("full_pop_push_rcnt", record_count, 16'd5);
    chk("full_pop_push_ocnt", overflow_count, 16'd2);
    for (int k = 1; k < 4; k++) begin
      expect_record(mk(16'h4000 + 16'(k), 16'h1000 + 16'(k), 16'h0001, 16'h0100 + 16'(k),
                       16'h0000, 16'h0000, 16'h0000),
                    7, 1'b0, $sformatf("ovf%0d", k), 1'b0, 16'h0, 16'h0);
    end
    expect_record(mk(16'h4006, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
                  7, 1'b0, "ovf_late", 1'b0, 16'h0, 16'h0);
    chk("ovf_drained", {15'b0, trace_valid}, 16'h0000);

    // ---------------- backpressure ----------------
    ld(16'h0A0A);
    fe(16'h4008, 16'h1111);
    st(16'h6000, 16'h1234);
    fe(16'h4009, 16'h3333);
    expect_record(mk(16'h4007, 16'h1111, 16'h0001, 16'h0A0A, 16'h0000, 16'h0000, 16'h0000),
                  7, 1'b1, "bp0", 1'b0, 16'h0, 16'h0);
    expect_record(mk(16'h4008, 16'h3333, 16'h0000, 16'h0000, 16'h0001, 16'h6000, 16'h1234),
                  7, 1'b1, "bp1", 1'b0, 16'h0, 16'h0);
    chk("bp_drained", {15'b0, trace_valid}, 16'h0000);
    chk("bp_rcnt", record_count, 16'd7);

    // ---------------- reset mid-record ----------------
    ld(16'h7777);
    fe(16'h400A, 16'h1444);
    expect_record(mk(16'h4009, 16'h1444, 16'h0001, 16'h7777, 16'h0000, 16'h0000, 16'h0000),
                  4, 1'b0, "mid", 1'b0, 16'h0, 16'h0);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_empty", {15'b0, trace_valid}, 16'h0000);
    fe(16'h5000, 16'h0000);
    fe(16'h5001, 16'h1555);
    expect_record(mk(16'h5000, 16'h1555, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
                  7, 1'b0, "post_rst", 1'b0, 16'h0, 16'h0);
    chk("post_rst_rcnt", record_count, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
